// File: rtl/ysyx_24080006_hpm_unit.sv
// ysyx_24080006_hpm_unit
// Machine-mode hardware performance monitor. It holds mcycle (counter 0),
// minstret (counter 2), mhpmcounter3..NUM_COUNTERS-1 with their high halves,
// mcountinhibit, the mhpmevent selectors and a sticky overflow register
// (mhpmovf, 0x7C0). The CSR file forwards accesses in this block's address
// range here and muxes csr_rdata back.
//
// Ports
//   clock, reset   core clock; synchronous active-high reset
//   event_i        per-cycle event pulses; an event selector value s counts event_i[s-1]
//   instret        at least one instruction retired this cycle (minstret +1)
//   count_freeze   global freeze of every counter (debug halt)
//   csr_valid      CSR access this cycle
//   csr_op         00 read, 01 write, 10 set, 11 clear
//   csr_addr       CSR address
//   csr_wdata      write/set/clear operand
//   csr_rdata      read data, combinational from csr_addr
//   csr_illegal    csr_addr is not owned here
//   ovf_irq        registered OR of the mhpmovf bits
module ysyx_24080006_hpm_unit #(
  parameter int NUM_COUNTERS  = 16,
  parameter int COUNTER_WIDTH = 64,
  parameter int NUM_EVENTS    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  instret,
  input  logic                  count_freeze,
  input  logic                  csr_valid,
  input  logic [1:0]            csr_op,
  input  logic [11:0]           csr_addr,
  input  logic [31:0]           csr_wdata,
  output logic [31:0]           csr_rdata,
  output logic                  csr_illegal,
  output logic                  ovf_irq
);

  localparam int NC = NUM_COUNTERS;
  localparam int EW = $clog2(NUM_EVENTS + 1);  // selector storage width
  localparam int HW = COUNTER_WIDTH - 32;      // high-half width

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Writable mcountinhibit bits: implemented counters, bit 1 (time) excluded.
  function automatic logic [31:0] impl_mask();
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < NUM_COUNTERS; i++)
      if (i != 1) m[i] = 1'b1;
    return m;
  endfunction
  localparam logic [31:0] INH_MASK = impl_mask();

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NC-1:0][COUNTER_WIDTH-1:0] cnt;  // cnt[1] is never written and stays 0
  logic [NC-1:0][EW-1:0]            sel;  // sel[0..2] are never written
  logic [31:0]                      inh;
  logic [NC-1:0]                    ovf;

  // ---------------------------------------------------------------------------
  // Address decode. Indices NC..31 are owned (read 0, ignore writes); only
  // counter 1 (time) is carved out of both counter windows.
  // ---------------------------------------------------------------------------
  logic [4:0] idx;
  logic       hit_inh, hit_evt, hit_lo, hit_hi, hit_ovf;

  assign idx     = csr_addr[4:0];
  assign hit_inh = (csr_addr == 12'h320);
  assign hit_evt = (csr_addr[11:5] == 7'h19) && (idx >= 5'd3);  // 0x323..0x33F
  assign hit_lo  = (csr_addr[11:5] == 7'h58) && (idx != 5'd1);  // 0xB00..0xB1F
  assign hit_hi  = (csr_addr[11:5] == 7'h5C) && (idx != 5'd1);  // 0xB80..0xB9F
  assign hit_ovf = (csr_addr == 12'h7C0);

  // Every owned address is writable, so ownership alone decides legality.
  assign csr_illegal = ~(hit_inh | hit_evt | hit_lo | hit_hi | hit_ovf);

  // ---------------------------------------------------------------------------
  // Read mux. The loop only matches implemented indices, so unimplemented
  // counters and selectors fall through to 0.
  // ---------------------------------------------------------------------------
  logic [63:0] wide;

  always_comb begin
    csr_rdata = '0;
    wide      = '0;
    if (hit_inh) begin
      csr_rdata = inh;
    end else if (hit_ovf) begin
      csr_rdata = 32'(ovf);
    end else begin
      for (int i = 0; i < NC; i++) begin
        if (idx == 5'(i)) begin
          wide = 64'(cnt[i]);  // zero-extends the high half when narrower than 64
          if (hit_lo)       csr_rdata = wide[31:0];
          else if (hit_hi)  csr_rdata = wide[63:32];
          else if (hit_evt) csr_rdata = 32'(sel[i]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path: value after write/set/clear, and the commit enable.
  // ---------------------------------------------------------------------------
  logic [31:0]   mval;
  logic          we;
  logic          ovf_wr;
  logic [EW-1:0] sel_wval;

  always_comb begin
    case (csr_op)
      OP_SET:   mval = csr_rdata | csr_wdata;
      OP_CLEAR: mval = csr_rdata & ~csr_wdata;
      default:  mval = csr_wdata;
    endcase
  end

  assign we     = csr_valid & (csr_op != OP_READ) & ~csr_illegal;
  assign ovf_wr = we & hit_ovf;

  // WARL selector: anything beyond the last event means "no event".
  assign sel_wval = (mval > 32'(NUM_EVENTS)) ? '0 : mval[EW-1:0];

  // ---------------------------------------------------------------------------
  // Per-counter increment, wrap and write strobes
  // ---------------------------------------------------------------------------
  logic [NUM_EVENTS:0] ev_ext;  // bit 0 is the "no event" slot for selector 0
  logic [NC-1:0]       src, inc, wrap, wr_lo, wr_hi, wr_evt;

  assign ev_ext = {event_i, 1'b0};

  always_comb begin
    src    = '0;
    inc    = '0;
    wrap   = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    wr_evt = '0;
    for (int i = 0; i < NC; i++) begin
      if (i == 0)      src[i] = 1'b1;
      else if (i == 2) src[i] = instret;
      else if (i >= 3) src[i] = ev_ext[sel[i]];
      inc[i]    = src[i] & ~inh[i] & ~count_freeze;
      wrap[i]   = inc[i] & (&cnt[i]);
      wr_lo[i]  = we & hit_lo  & (idx == 5'(i));
      wr_hi[i]  = we & hit_hi  & (idx == 5'(i));
      wr_evt[i] = we & hit_evt & (idx == 5'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // State update. A CSR write to a counter half replaces the increment and
  // clears that counter's overflow bit (a same-cycle wrap is discarded).
  // An mhpmovf write can only clear bits; a wrap in the same cycle still sets
  // its bit so an overflow is never lost.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      sel     <= '0;
      inh     <= '0;
      ovf     <= '0;
      ovf_irq <= 1'b0;
    end else begin
      if (we & hit_inh) inh <= mval & INH_MASK;
      for (int i = 0; i < NC; i++) begin
        if (wr_lo[i])      cnt[i][31:0]               <= mval;
        else if (wr_hi[i]) cnt[i][COUNTER_WIDTH-1:32] <= mval[HW-1:0];
        else if (inc[i])   cnt[i]                     <= cnt[i] + COUNTER_WIDTH'(1);

        if (wr_evt[i]) sel[i] <= sel_wval;

        if (wr_lo[i] | wr_hi[i]) ovf[i] <= 1'b0;
        else                     ovf[i] <= (ovf[i] & (~ovf_wr | mval[i])) | wrap[i];
      end
      ovf_irq <= |ovf;
    end
  end

endmodule
